rx_frame_buffer_ctrl: RTL

- Receive-side frame buffer controller between the MAC receive path and the host/consumer.
- Accepts the byte stream from the receiver (data/enable/start/end/error) and writes it into an internal circular byte buffer. Good frames are committed atomically; errored or overflowed frames are rewound and discarded.
- Committed frames are replayed on a valid/ready stream with start/end markers.
- Drives the `fifo_full` back-pressure flag consumed by the receiver state machine.

---
 rtl/rx_frame_buffer_ctrl.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/rx_frame_buffer_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : rx_frame_buffer_ctrl
// Function : receive frame buffer, atomic commit/rewind, valid/ready replay
// Revision : 1.0  initial release
// ============================================================================
module rx_frame_buffer_ctrl #(
  parameter int ADDR_WIDTH = 11,
  parameter int DESC_AW    = 2,
  parameter int LEN_WIDTH  = 12
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [7:0]  in_data,
  input  logic        in_enable,
  input  logic        in_start,
  input  logic        in_end,
  input  logic        in_error,
  output logic        fifo_full,
  output logic [7:0]  out_data,
  output logic        out_valid,
  output logic        out_start,
  output logic        out_end,
  input  logic        out_ready,
  output logic [15:0] frames_ok,
  output logic [15:0] frames_dropped
);
  localparam int DEPTH  = 1 << ADDR_WIDTH;
  localparam int PW     = ADDR_WIDTH + 1;
  localparam int DPW    = DESC_AW + 1;
  localparam int DDEPTH = 1 << DESC_AW;
  localparam logic [PW-1:0]        C_DEPTH    = PW'(DEPTH);
  localparam logic [PW-1:0]        C_DEPTH_M1 = PW'(DEPTH - 1);
  localparam logic [PW-1:0]        C_PTR_ONE  = PW'(1);
  localparam logic [DPW-1:0]       C_DDEPTH   = DPW'(DDEPTH);
  localparam logic [DPW-1:0]       C_DPTR_ONE = DPW'(1);
  localparam logic [LEN_WIDTH-1:0] C_LEN_MAX  = '1;
  localparam logic [LEN_WIDTH-1:0] C_LEN_ONE  = LEN_WIDTH'(1);

  typedef enum logic [0:0] {W_IDLE, W_FRAME} wstate_t;
  typedef enum logic [1:0] {R_IDLE, R_LOAD, R_STREAM} rstate_t;

  wstate_t r_wstate, w_wstate_next;
  rstate_t r_rstate, w_rstate_next;

  logic [7:0]           r_mem [DEPTH];
  logic [LEN_WIDTH-1:0] r_desc_len [DDEPTH];
  logic [PW-1:0]        r_wr_ptr, r_cm_ptr, r_rd_ptr;
  logic [DPW-1:0]       r_desc_wp, r_desc_wp_vis, r_desc_rp;
  logic [LEN_WIDTH-1:0] r_len, r_remaining;
  logic                 r_ovf, r_fifo_full;
  logic [7:0]           r_out_data;
  logic                 r_out_valid, r_out_start;
  logic [15:0]          r_frames_ok, r_frames_dropped;

  logic                 w_sof, w_restart, w_active, w_base_full, w_ovf_cur, w_ovf_next;
  logic                 w_do_write, w_end, w_bad, w_commit, w_desc_full, w_desc_empty;
  logic [PW-1:0]        w_base, w_wr_next, w_used;
  logic [LEN_WIDTH-1:0] w_len_cur, w_len_next;
  logic [1:0]           w_drops;
  logic [16:0]          w_drop_sum;
  logic                 w_accept, w_last, w_fetch;

  assign w_used       = r_wr_ptr - r_rd_ptr;
  assign w_desc_full  = (r_desc_wp - r_desc_rp) == C_DDEPTH;
  // Reader sees pushes one cycle late, fixing commit-to-out_valid latency at 3.
  assign w_desc_empty = r_desc_wp_vis == r_desc_rp;

  // A start inside a frame restarts from cm_ptr, so all write math uses w_base.
  always_comb begin
    w_sof       = in_enable & in_start;
    w_restart   = (r_wstate == W_FRAME) & w_sof;
    w_active    = (r_wstate == W_FRAME) | w_sof;
    w_base      = w_restart ? r_cm_ptr : r_wr_ptr;
    w_base_full = (w_base - r_rd_ptr) == C_DEPTH;
    w_len_cur   = w_sof ? '0 : r_len;
    w_ovf_cur   = w_sof ? w_desc_full : r_ovf;
    w_do_write  = w_active & in_enable & ~w_ovf_cur & ~w_base_full;
    w_len_next  = w_len_cur + LEN_WIDTH'(w_do_write);
    w_ovf_next  = w_ovf_cur | (w_active & in_enable & w_base_full) | (w_len_next == C_LEN_MAX);
    w_wr_next   = w_base + PW'(w_do_write);
    w_end       = w_active & in_end;
    w_bad       = in_error | w_ovf_next;
    w_commit    = w_end & ~w_bad;
    w_drops     = {1'b0, w_restart} + {1'b0, w_end & w_bad};
    w_drop_sum  = {1'b0, r_frames_dropped} + 17'(w_drops);
  end

  always_comb begin
    w_wstate_next = r_wstate;
    if (w_end)      w_wstate_next = W_IDLE;
    else if (w_sof) w_wstate_next = W_FRAME;
  end

  always_comb begin
    w_rstate_next = r_rstate;
    w_accept      = (r_rstate == R_STREAM) & r_out_valid & out_ready;
    w_last        = r_remaining == C_LEN_ONE;
    w_fetch       = (r_rstate == R_LOAD) | ((r_rstate == R_STREAM) & ~r_out_valid);
    case (r_rstate)
      R_IDLE:   if (!w_desc_empty) w_rstate_next = R_LOAD;
      R_LOAD:   w_rstate_next = R_STREAM;
      R_STREAM: if (w_accept & w_last) w_rstate_next = R_IDLE;
      default:  w_rstate_next = R_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (w_do_write) r_mem[w_base[ADDR_WIDTH-1:0]] <= in_data;
    if (w_commit)   r_desc_len[r_desc_wp[DESC_AW-1:0]] <= w_len_next;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_wstate         <= W_IDLE;
      r_rstate         <= R_IDLE;
      r_wr_ptr         <= '0;
      r_cm_ptr         <= '0;
      r_rd_ptr         <= '0;
      r_desc_wp        <= '0;
      r_desc_wp_vis    <= '0;
      r_desc_rp        <= '0;
      r_len            <= '0;
      r_remaining      <= '0;
      r_ovf            <= 1'b0;
      r_fifo_full      <= 1'b0;
      r_out_data       <= '0;
      r_out_valid      <= 1'b0;
      r_out_start      <= 1'b0;
      r_frames_ok      <= '0;
      r_frames_dropped <= '0;
    end else begin
      r_wstate      <= w_wstate_next;
      r_rstate      <= w_rstate_next;
      r_desc_wp_vis <= r_desc_wp;
      r_fifo_full   <= (w_used >= C_DEPTH_M1) | w_desc_full | r_ovf;

      if (w_end) begin
        r_len <= '0;
        r_ovf <= 1'b0;
        if (w_bad) begin
          r_wr_ptr <= r_cm_ptr;
        end else begin
          r_wr_ptr  <= w_wr_next;
          r_cm_ptr  <= w_wr_next;
          r_desc_wp <= r_desc_wp + C_DPTR_ONE;
        end
      end else if (w_active) begin
        r_len    <= w_len_next;
        r_ovf    <= w_ovf_next;
        r_wr_ptr <= w_wr_next;
      end

      if (w_commit && r_frames_ok != 16'hFFFF) r_frames_ok <= r_frames_ok + 16'd1;
      r_frames_dropped <= w_drop_sum[16] ? 16'hFFFF : w_drop_sum[15:0];

      if (r_rstate == R_IDLE && !w_desc_empty)
        r_remaining <= r_desc_len[r_desc_rp[DESC_AW-1:0]];
      if (w_fetch) begin
        r_out_data  <= r_mem[r_rd_ptr[ADDR_WIDTH-1:0]];
        r_out_valid <= 1'b1;
        r_out_start <= (r_rstate == R_LOAD);
      end else if (w_accept) begin
        r_out_valid <= 1'b0;
        r_out_start <= 1'b0;
        r_rd_ptr    <= r_rd_ptr + C_PTR_ONE;
        r_remaining <= r_remaining - C_LEN_ONE;
        if (w_last) r_desc_rp <= r_desc_rp + C_DPTR_ONE;
      end
    end
  end

  assign fifo_full      = r_fifo_full;
  assign out_data       = r_out_data;
  assign out_valid      = r_out_valid;
  assign out_start      = r_out_start;
  assign out_end        = r_out_valid & (r_remaining == C_LEN_ONE);
  assign frames_ok      = r_frames_ok;
  assign frames_dropped = r_frames_dropped;

endmodule
`default_nettype wire
